// File: rtl/if_axi_rd_if.sv
// AXI4 read-address / read-data channel bundle between the fetch unit and memory.
interface if_axi_rd_if #(
   parameter int unsigned AXI_ID_W = 4
);
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;

   logic                ar_valid_o;
   logic                ar_ready_i;
   logic [ADDR_W-1:0]   ar_addr_o;
   logic [AXI_ID_W-1:0] ar_id_o;
   logic [7:0]          ar_len_o;
   logic [2:0]          ar_size_o;
   logic [1:0]          ar_burst_o;

   logic                r_valid_i;
   logic                r_ready_o;
   logic [DATA_W-1:0]   r_data_i;
   logic [1:0]          r_resp_i;
   logic                r_last_i;
   logic [AXI_ID_W-1:0] r_id_i;

   modport master (
      output ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, r_ready_o,
      input  ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i
   );

   modport slave (
      input  ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, r_ready_o,
      output ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i
   );
endinterface

// File: rtl/if_axi_rd.sv
// Instruction-fetch to AXI4 read bridge: one single-beat read outstanding,
// with kill on flush/redirect and word alignment of the returned beat.
module if_axi_rd #(
   parameter int unsigned AXI_ID_W = 4,
   parameter int unsigned IF_RD_ID = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid_i,
   input  logic [63:0] if_addr_i,
   input  logic [1:0]  if_size_i,
   input  logic        if_req_i,
   output logic        if_ready_o,
   output logic [63:0] if_data_read_o,
   output logic [1:0]  if_resp_o,
   if_axi_rd_if.master axi
);
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned HALF_W = DATA_W / 2;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          size_q, size_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [1:0]          resp_q, resp_d;
   logic                ar_valid_q;
   logic                r_ready_q;
   logic                unused_c;

   // Next-state and captured-data logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      data_d  = data_q;
      resp_d  = resp_q;
      case (state_q)
         IDLE: begin
            if (if_valid_i && !if_req_i) begin
               addr_d  = if_addr_i;
               size_d  = if_size_i;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (axi.ar_ready_i) state_d = DATA;
         end
         DATA: begin
            if (axi.r_valid_i) begin
               // A flushed or redirected fetch drops the beat silently
               if (if_valid_i && (if_addr_i == addr_q)) begin
                  state_d = RESP;
                  data_d  = addr_q[2] ? {HALF_W'(0), axi.r_data_i[DATA_W-1:HALF_W]}
                                      : axi.r_data_i;
                  resp_d  = axi.r_resp_i;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         data_q     <= '0;
         resp_q     <= '0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         data_q     <= data_d;
         resp_q     <= resp_d;
         ar_valid_q <= (state_d == ADDR);
         r_ready_q  <= (state_d == DATA);
      end
   end

   // Completion pulse is withdrawn if the fetch address moved during RESP
   assign if_ready_o     = (state_q == RESP) && (if_addr_i == addr_q);
   assign if_data_read_o = data_q;
   assign if_resp_o      = resp_q;

   assign axi.ar_valid_o = ar_valid_q;
   assign axi.ar_addr_o  = addr_q;
   assign axi.ar_size_o  = {1'b0, size_q};
   assign axi.ar_len_o   = 8'd0;
   assign axi.ar_burst_o = 2'b01;
   assign axi.ar_id_o    = AXI_ID_W'(IF_RD_ID);
   assign axi.r_ready_o  = r_ready_q;

   // Single-beat, single-ID reads: last and ID carry no information
   assign unused_c = ^{axi.r_last_i, axi.r_id_i};
endmodule

// File: doc/if_axi_rd.md
IF_AXI_RD -- requirements
Module: if_axi_rd

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 4, width of AXI ID fields.
REQ-002 SHALL have parameter IF_RD_ID, default 0, constant ARID driven on every fetch request.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_valid_i  input  1  fetch request from IF stage, held until if_ready_o.
REQ-006 SHALL have port if_addr_i  input  64  fetch byte address.
REQ-007 SHALL have port if_size_i  input  2  log2 bytes; 2'b10 = word.
REQ-008 SHALL have port if_req_i  input  1  request type; only read (0) is serviced.
REQ-009 SHALL have port if_ready_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port if_data_read_o  output  64  fetched data, instruction in [31:0].
REQ-011 SHALL have port if_resp_o  output  2  AXI response of the completed fetch.
REQ-012 SHALL have AR ports: ar_valid_o out 1, ar_ready_i in 1, ar_addr_o out 64, ar_id_o out AXI_ID_W, ar_len_o out 8, ar_size_o out 3, ar_burst_o out 2.
REQ-013 SHALL have R ports: r_valid_i in 1, r_ready_o out 1, r_data_i in 64, r_resp_i in 2, r_last_i in 1, r_id_i in AXI_ID_W.

Function
REQ-014 SHALL implement FSM IDLE, ADDR, DATA, RESP; encoding free.
REQ-015 IDLE: when if_valid_i=1, SHALL latch if_addr_i and if_size_i and enter ADDR next cycle.
REQ-016 ADDR: ar_valid_o=1 (registered), ar_addr_o=latched address, ar_size_o={1'b0,latched size}, ar_len_o=0, ar_burst_o=2'b01, ar_id_o=IF_RD_ID; on ar_ready_i=1 SHALL enter DATA.
REQ-017 ar_valid_o SHALL stay 1 and AR fields stable until ar_ready_i, regardless of if_valid_i or if_addr_i changes (AXI no-retract rule).
REQ-018 DATA: r_ready_o=1; on r_valid_i=1 SHALL capture r_data_i and r_resp_i; r_last_i and r_id_i are ignored (single-beat, single ID).
REQ-019 Data alignment: latched addr[2]=1 -> captured data = {32'b0, r_data_i[63:32]}; addr[2]=0 -> r_data_i unchanged.
REQ-020 Kill: at the R-beat cycle, if if_valid_i=0 or if_addr_i != latched address, SHALL discard the beat and return to IDLE with no if_ready_o pulse.
REQ-021 Otherwise SHALL enter RESP; in RESP, if_ready_o=1 for exactly one cycle with registered if_data_read_o and if_resp_o, then IDLE.
REQ-022 In RESP, if_ready_o SHALL be gated by (if_addr_i == latched address); a mismatch suppresses the pulse and still returns to IDLE.
REQ-023 Minimum latency with ar_ready_i and r_valid_i both asserted at the earliest cycle: if_valid_i at cycle 0 -> ar_valid_o cycle 1 -> r_ready_o cycle 2 -> if_ready_o cycle 3.
REQ-024 A request still valid in IDLE immediately after a kill or completion SHALL be re-issued at the next cycle using the current if_addr_i.
REQ-025 SLVERR/DECERR (r_resp_i[1]=1) SHALL complete normally with if_resp_o=r_resp_i; no retry.
REQ-026 if_req_i=1 (write) SHALL be ignored in IDLE; the FSM stays in IDLE.
REQ-027 if_data_read_o and if_resp_o SHALL hold their last values outside RESP; if_ready_o=0 outside RESP.
REQ-028 At most one AR SHALL be outstanding.

Reset
REQ-029 On rst=0, asynchronously: FSM=IDLE, ar_valid_o=0, r_ready_o=0, if_ready_o=0, if_data_read_o=0, if_resp_o=0, ar_addr_o=0, latched address=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction; the AXI slave shares rst, and no response is delivered after release.
REQ-031 Constant outputs ar_len_o=0, ar_burst_o=2'b01, ar_id_o=IF_RD_ID SHALL hold in and out of reset.

Verification
REQ-032 Basic fetch: addr 0x80000000, size 2'b10, ar_ready and r_valid=1 with data 0x11112222_33334444 -> if_ready at cycle 3, if_data_read=0x11112222_33334444, if_resp=0.
REQ-033 Upper word: addr 0x80000004, same data -> if_data_read=0x00000000_11112222.
REQ-034 AR backpressure: ar_ready=0 for 5 cycles, then if_addr changes to 0x80000100 -> ar_valid and ar_addr=0x80000000 stable throughout; beat discarded; new AR for 0x80000100 issued afterwards.
REQ-035 Flush: if_valid drops during DATA before r_valid -> no if_ready pulse; FSM returns to IDLE after the beat.
REQ-036 Error: r_resp=2'b10 -> if_ready pulse with if_resp=2'b10.
REQ-037 Reset asserted while in DATA -> all outputs 0 within the same cycle; a fresh request after release completes normally.
